lut_decoder_stim_gen: RTL
=========================

# lut_decoder_stim_gen

Clocked stimulus sequencer for the lut_decoder verification bench, the driving counterpart of the lut_decoder checker. Sweeps mode, format, iteration index n and every legal BKM digit pair (d_x_n, d_y_n), presents one vector per enabled cycle to the DUT and the reference model, and produces the checker `enable` strobe aligned to the DUT pipeline latency. Signals end-of-sweep with a sticky `done`.

## Interface
- `LOG2N`, 6: width of `tb_n`.
- `N_ITER`, 64: iterations swept, n = 0..N_ITER-1; 1 <= N_ITER <= 2**LOG2N.
- `LAT`, 1: DUT result latency in cycles, 0..15; delay from vector issue to checker `enable`.
- `WCNT`, 16: width of the vector counter.
- `clk`  in  1  bench clock, rising edge.
- `arst`  in  1  asynchronous reset, active-high; one clock; reset is asynchronous and active-high.
- `srst`  in  1  synchronous reset, active-high, same effect as `arst`.
- `start`  in  1  single-cycle pulse; starts a sweep from IDLE or DONE.
- `enable`  in  1  advance permission; low stalls the sweep.
- `tb_mode`  out  1  mode under test.
- `tb_format`  out  2  format under test.
- `tb_n`  out  LOG2N  iteration index.
- `tb_d_x_n`, `tb_d_y_n`  out  2 each  digits: 2'b11 = -1, 2'b00 = 0, 2'b01 = +1.
- `vec_valid`  out  1  current outputs are a new vector this cycle.
- `chk_enable`  out  1  `vec_valid` delayed LAT cycles; drives checker `enable`.
- `vec_cnt`  out  WCNT  vectors issued since start.
- `busy`  out  1  state is RUN or DRAIN.
- `done`  out  1  sweep complete, sticky.

## Operation
- FSM: IDLE, RUN, DRAIN, DONE.
- IDLE --start--> RUN. DONE --start--> RUN and clears `done` and `vec_cnt`. `start` in RUN/DRAIN is ignored.
- RUN: each cycle with `enable` = 1 issues the current vector (`vec_valid` = 1), increments `vec_cnt`, then advances the odometer. Odometer order, innermost first:
  - d_y: 00 -> 01 -> 11 -> wrap to 00.
  - d_x: same order.
  - n: 0..N_ITER-1.
  - format: 0..3.
  - mode: 0..1.
- Encoding 2'b10 is never emitted.
- Total vectors: 2*4*N_ITER*9 (4608 at defaults). After the last vector issues, RUN -> DRAIN; the odometer stays on the last vector.
- `enable` = 0 in RUN: outputs hold, `vec_valid` = 0, nothing advances. The delay line keeps shifting.
- DRAIN: wait until the delay line is empty (LAT cycles after the last issue), then go to DONE and set `done` = 1. With LAT = 0, go straight to DONE on the cycle after the last issue.
- `vec_cnt` saturates at all-ones.

## Timing
- Reset (`arst` asynchronous, or `srst` sampled at an edge), from any state including mid-sweep:
  - state -> IDLE.
  - All outputs 0.
  - Odometer 0; delay line cleared.
  - A pending `chk_enable` is dropped.
- `srst` has priority over `start`.
- First vector appears on the first edge after `start` is sampled (1-cycle latency), provided `enable` = 1 at that edge.
- Vector outputs and `vec_valid` are registered. `chk_enable` at cycle t equals `vec_valid` at cycle t-LAT.
- `busy` is high from the cycle after `start` through the last DRAIN cycle. `done` rises the same edge `busy` falls.

## Structure
- Package `lut_decoder_tb_pkg`:
  - digit constants DIG_M1 = 2'b11, DIG_Z = 2'b00, DIG_P1 = 2'b01;
  - state typedef;
  - function `n_vectors(N_ITER)`.
- Sub-module `valid_delay_line` (depth LAT, async + sync clear), instantiated once for `chk_enable`.

## Test plan
- Defaults; `start` with `enable` held high -> 4608 `vec_valid` pulses; the first vector (mode 0, format 0, n 0, d_x 00, d_y 00) appears 1 cycle after `start`; `done` rises exactly 1 cycle after the last `chk_enable`; `vec_cnt` = 4608.
- N_ITER = 2, LAT = 3 -> 144 vectors; `chk_enable` equals `vec_valid` shifted by 3; the sequence at vectors 2..4 is (d_x 00, d_y 11), (01, 00), (01, 01); 2'b10 never appears.
- `enable` toggled 1/0 every cycle -> outputs stable across stalls, 4608 pulses total, no vector duplicated or skipped.
- `arst` pulsed mid-RUN at `vec_cnt` = 100 -> all outputs 0 immediately; a later `start` restarts at vector 0 with `vec_cnt` = 0.
- `start` during RUN -> ignored; `start` in DONE -> `done` clears and a new full sweep runs.
- LAT = 0 -> `chk_enable` == `vec_valid`; DONE is reached 1 cycle after the last vector.

Source files
------------

// File: rtl/lut_decoder_stim_gen_pkg.sv
// Shared types and helpers for the lut_decoder stimulus sequencer.
`timescale 1ns/1ps
package lut_decoder_tb_pkg;

  // BKM digit encodings; 2'b10 is reserved and never generated
  localparam logic [1:0] DIG_M1 = 2'b11;
  localparam logic [1:0] DIG_Z  = 2'b00;
  localparam logic [1:0] DIG_P1 = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Vectors in one full sweep: 2 modes x 4 formats x N_ITER x 9 digit pairs
  function automatic int unsigned n_vectors(input int unsigned n_iter);
    return 2 * 4 * n_iter * 9;
  endfunction

  // Digit odometer step: 0 -> +1 -> -1 -> 0
  function automatic logic [1:0] dig_next(input logic [1:0] d);
    logic [1:0] r;
    case (d)
      DIG_Z:   r = DIG_P1;
      DIG_P1:  r = DIG_M1;
      default: r = DIG_Z;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lut_decoder_stim_gen_if.sv
// Control and vector bus between the stimulus sequencer and its consumers.
`timescale 1ns/1ps
interface lut_decoder_stim_gen_if #(
  parameter int LOG2N = 6,
  parameter int WCNT  = 16
);
  logic             start;
  logic             enable;
  logic             tb_mode;
  logic [1:0]       tb_format;
  logic [LOG2N-1:0] tb_n;
  logic [1:0]       tb_d_x_n;
  logic [1:0]       tb_d_y_n;
  logic             vec_valid;
  logic             chk_enable;
  logic [WCNT-1:0]  vec_cnt;
  logic             busy;
  logic             done;

  modport master (
    input  start, enable,
    output tb_mode, tb_format, tb_n, tb_d_x_n, tb_d_y_n,
    output vec_valid, chk_enable, vec_cnt, busy, done
  );

  modport slave (
    output start, enable,
    input  tb_mode, tb_format, tb_n, tb_d_x_n, tb_d_y_n,
    input  vec_valid, chk_enable, vec_cnt, busy, done
  );
endinterface

// File: rtl/lut_decoder_stim_gen_valid_delay_line.sv
// Delays the vector-valid strobe by LAT cycles to line up with DUT results.
// `drained` is high when no strobe is still travelling toward the output
// (the one currently on vld_out, if any, counts as delivered).
`timescale 1ns/1ps
module valid_delay_line #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic arst,
  input  logic srst,
  input  logic vld_in,
  output logic vld_out,
  output logic drained
);

  if (LAT == 0) begin : g_pass
    assign vld_out = vld_in;
    assign drained = 1'b1;
  end else if (LAT == 1) begin : g_one
    logic vld_p1;

    // Single stage: input -> output
    always_ff @(posedge clk or posedge arst) begin
      if (arst)      vld_p1 <= 1'b0;
      else if (srst) vld_p1 <= 1'b0;
      else           vld_p1 <= vld_in;
    end

    assign vld_out = vld_p1;
    assign drained = ~vld_in;
  end else begin : g_multi
    logic [LAT-1:0] vld_pipe;

    // Shift register: bit 0 is one cycle old, bit LAT-1 is LAT cycles old
    always_ff @(posedge clk or posedge arst) begin
      if (arst)      vld_pipe <= '0;
      else if (srst) vld_pipe <= '0;
      else           vld_pipe <= {vld_pipe[LAT-2:0], vld_in};
    end

    assign vld_out = vld_pipe[LAT-1];
    assign drained = ~(vld_in | (|vld_pipe[LAT-2:0]));
  end

endmodule

// File: rtl/lut_decoder_stim_gen.sv
// Stimulus sequencer for the lut_decoder bench: sweeps mode, format, n and
// all legal (d_x, d_y) digit pairs, one vector per enabled RUN cycle, and
// produces a latency-aligned checker enable plus a sticky done.
`timescale 1ns/1ps
module lut_decoder_stim_gen
  import lut_decoder_tb_pkg::*;
#(
  parameter int LOG2N  = 6,
  parameter int N_ITER = 64,
  parameter int LAT    = 1,
  parameter int WCNT   = 16
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  srst,
  lut_decoder_stim_gen_if.master bus
);

  localparam logic [LOG2N-1:0] N_LAST = LOG2N'(N_ITER - 1);

  state_t state_q, state_d;

  // Odometer: the next vector to be issued
  logic             odo_mode, odo_mode_nx;
  logic [1:0]       odo_fmt, odo_fmt_nx;
  logic [LOG2N-1:0] odo_n, odo_n_nx;
  logic [1:0]       odo_dx, odo_dx_nx;
  logic [1:0]       odo_dy, odo_dy_nx;

  // Presented vector and its strobe
  logic             mode_p0;
  logic [1:0]       fmt_p0;
  logic [LOG2N-1:0] n_p0;
  logic [1:0]       dx_p0;
  logic [1:0]       dy_p0;
  logic             vld_p0;
  logic [WCNT-1:0]  cnt_p0;

  logic issue;
  logic last_vec;
  logic start_go;
  logic chk_en;
  logic dl_drained;
  logic busy_c;
  logic done_c;

  assign issue    = (state_q == ST_RUN) && bus.enable;
  assign start_go = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last_vec = odo_mode && (odo_fmt == 2'd3) && (odo_n == N_LAST) &&
                    (odo_dx == DIG_M1) && (odo_dy == DIG_M1);

  // State register
  always_ff @(posedge clk or posedge arst) begin
    if (arst)      state_q <= ST_IDLE;
    else if (srst) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_RUN;
      ST_RUN:   if (issue && last_vec) state_d = ST_DRAIN;
      ST_DRAIN: if (dl_drained) state_d = ST_DONE;
      ST_DONE:  if (bus.start) state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State-decoded status outputs
  always_comb begin
    busy_c = 1'b0;
    done_c = 1'b0;
    case (state_q)
      ST_RUN, ST_DRAIN: busy_c = 1'b1;
      ST_DONE:          done_c = 1'b1;
      default:          ;
    endcase
  end

  // Odometer increment: d_y innermost, then d_x, n, format, mode
  always_comb begin
    odo_dy_nx   = dig_next(odo_dy);
    odo_dx_nx   = odo_dx;
    odo_n_nx    = odo_n;
    odo_fmt_nx  = odo_fmt;
    odo_mode_nx = odo_mode;
    if (odo_dy == DIG_M1) begin
      odo_dx_nx = dig_next(odo_dx);
      if (odo_dx == DIG_M1) begin
        if (odo_n == N_LAST) begin
          odo_n_nx   = '0;
          odo_fmt_nx = odo_fmt + 2'd1;
          if (odo_fmt == 2'd3) odo_mode_nx = ~odo_mode;
        end else begin
          odo_n_nx = odo_n + 1'b1;
        end
      end
    end
  end

  // Odometer advance; it parks on the last vector once the sweep ends
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      odo_mode <= 1'b0;
      odo_fmt  <= '0;
      odo_n    <= '0;
      odo_dx   <= DIG_Z;
      odo_dy   <= DIG_Z;
    end else if (srst || start_go) begin
      odo_mode <= 1'b0;
      odo_fmt  <= '0;
      odo_n    <= '0;
      odo_dx   <= DIG_Z;
      odo_dy   <= DIG_Z;
    end else if (issue && !last_vec) begin
      odo_mode <= odo_mode_nx;
      odo_fmt  <= odo_fmt_nx;
      odo_n    <= odo_n_nx;
      odo_dx   <= odo_dx_nx;
      odo_dy   <= odo_dy_nx;
    end
  end

  // Issue stage (p0): register the vector, its strobe and the saturating count
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      mode_p0 <= 1'b0;
      fmt_p0  <= '0;
      n_p0    <= '0;
      dx_p0   <= '0;
      dy_p0   <= '0;
      vld_p0  <= 1'b0;
      cnt_p0  <= '0;
    end else if (srst) begin
      mode_p0 <= 1'b0;
      fmt_p0  <= '0;
      n_p0    <= '0;
      dx_p0   <= '0;
      dy_p0   <= '0;
      vld_p0  <= 1'b0;
      cnt_p0  <= '0;
    end else begin
      vld_p0 <= issue;
      if (start_go) cnt_p0 <= '0;
      if (issue) begin
        mode_p0 <= odo_mode;
        fmt_p0  <= odo_fmt;
        n_p0    <= odo_n;
        dx_p0   <= odo_dx;
        dy_p0   <= odo_dy;
        if (cnt_p0 != '1) cnt_p0 <= cnt_p0 + 1'b1;
      end
    end
  end

  valid_delay_line #(
    .LAT (LAT)
  ) u_dly (
    .clk     (clk),
    .arst    (arst),
    .srst    (srst),
    .vld_in  (vld_p0),
    .vld_out (chk_en),
    .drained (dl_drained)
  );

  assign bus.tb_mode    = mode_p0;
  assign bus.tb_format  = fmt_p0;
  assign bus.tb_n       = n_p0;
  assign bus.tb_d_x_n   = dx_p0;
  assign bus.tb_d_y_n   = dy_p0;
  assign bus.vec_valid  = vld_p0;
  assign bus.chk_enable = chk_en;
  assign bus.vec_cnt    = cnt_p0;
  assign bus.busy       = busy_c;
  assign bus.done       = done_c;

endmodule
